// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - serial framed image loader: bytes to 32-bit RAM words, holds core until checksum passes
module boot_loader #(
  parameter int         ADDRWIDTH = 10,
  parameter int         RAMDEPTH  = 1024,
  parameter int         BASEADDR  = 0,
  parameter logic [7:0] SYNCBYTE  = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 core_hold,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0]          DEPTH_L = 17'(RAMDEPTH);
  localparam logic [ADDRWIDTH-1:0] BASE_L  = ADDRWIDTH'(BASEADDR);

  state_t      state;
  logic [7:0]  xor_acc;
  logic [1:0]  byte_idx;
  logic [7:0]  len_lo;
  logic [15:0] len_n;
  logic [23:0] word_reg;

  logic        xfer;
  logic [31:0] word_next;
  logic [15:0] len_rx;
  logic [15:0] words_next;

  // transfer qualifier and the word/length values formed from the incoming byte
  always_comb begin
    xfer       = in_valid & in_ready;
    word_next  = {in_data, word_reg};
    len_rx     = {in_data, len_lo};
    words_next = words_loaded + 16'd1;
  end

  // frame parser FSM with all outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      xor_acc      <= 8'h00;
      byte_idx     <= 2'd0;
      len_lo       <= 8'h00;
      len_n        <= 16'd0;
      word_reg     <= 24'd0;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_L;
      mem_wdata    <= 32'd0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          // anything other than the sync marker is consumed and dropped
          if (xfer && in_data == SYNCBYTE) begin
            state        <= S_LEN0;
            xor_acc      <= 8'h00;
            byte_idx     <= 2'd0;
            words_loaded <= 16'd0;
          end
        end
        S_LEN0: begin
          if (xfer) begin
            len_lo  <= in_data;
            xor_acc <= xor_acc ^ in_data;
            state   <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            xor_acc <= xor_acc ^ in_data;
            len_n   <= len_rx;
            if ({1'b0, len_rx} > DEPTH_L) begin
              state    <= S_ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else if (len_rx == 16'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            xor_acc  <= xor_acc ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            word_reg <= word_next[31:8];
            if (byte_idx == 2'd3) begin
              // address wraps naturally at the RAM width
              mem_we       <= 1'b1;
              mem_addr     <= BASE_L + ADDRWIDTH'(words_loaded);
              mem_wdata    <= word_next;
              words_loaded <= words_next;
              if (words_next == len_n) begin
                state <= S_CHK;
              end
            end
          end
        end
        S_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == xor_acc) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed scoreboard bench for boot_loader
module tb_boot_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int          n_cmp = 0;
  int          n_err = 0;
  int          spurious = 0;
  bit          gaps = 0;
  logic [47:0] exp_q[$];
  logic [31:0] frame_words[$];

  boot_loader dut (
    .clock        (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // write monitor: every mem_we pops the scoreboard
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        spurious++;
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {22'd0, mem_addr}, {16'd0, e[47:32]});
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int waitc;
    waitc = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 20) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic flip);
    logic [7:0]  chk;
    logic [15:0] n;
    logic [31:0] w;
    logic [7:0]  b;
    n   = 16'(frame_words.size());
    chk = n[7:0] ^ n[15:8];
    send(8'hA5);
    send(n[7:0]);
    send(n[15:8]);
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      for (int k = 0; k < 4; k++) begin
        b   = w[8*k +: 8];
        chk = chk ^ b;
        if (k == 3) exp_q.push_back({16'(i), w});
        send(b);
      end
    end
    send(chk ^ {7'd0, flip});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_scoreboard(input string tag);
    @(negedge clk);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_spurious"}, 32'(spurious), 32'd0);
    exp_q.delete();
    spurious = 0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic h, input logic r, input logic [15:0] wl);
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_error"}, {31'd0, error}, {31'd0, e});
    check({tag, "_core_hold"}, {31'd0, core_hold}, {31'd0, h});
    check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, r});
    check({tag, "_words"}, {16'd0, words_loaded}, {16'd0, wl});
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    do_reset();

    // reset state
    check_status("rst", 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);

    // two-word good frame
    frame_words = '{32'h12345678, 32'hDEADBEEF};
    send_frame(1'b0);
    check_status("good2", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    check_scoreboard("good2");

    // same frame, corrupted checksum
    do_reset();
    send_frame(1'b1);
    check_status("badchk", 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    // bytes offered while stalled must not be consumed
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_status("badchk_hold", 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    check_scoreboard("badchk");

    // garbage before sync, single word
    do_reset();
    send(8'h00);
    send(8'hFF);
    send(8'h13);
    frame_words = '{32'h00000001};
    send_frame(1'b0);
    check_status("garbage", 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    check_scoreboard("garbage");

    // empty image
    do_reset();
    frame_words.delete();
    send_frame(1'b0);
    check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    check_scoreboard("empty");

    // oversize length rejected right after LEN_HI
    do_reset();
    send(8'hA5);
    send(8'h01);
    send(8'h04);
    check_status("oversize", 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    check_scoreboard("oversize");

    // reset mid-frame, then a frame carrying sync-valued data
    do_reset();
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h78);
    send(8'h56);
    do_reset();
    check_status("midrst", 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    check("midrst_addr", {22'd0, mem_addr}, 32'd0);
    check("midrst_wdata", mem_wdata, 32'd0);
    frame_words = '{32'hA50000A5, 32'h11223344};
    send_frame(1'b0);
    check_status("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    check_scoreboard("after_rst");

    // first frame again with random valid gaps
    do_reset();
    gaps = 1;
    frame_words = '{32'h12345678, 32'hDEADBEEF};
    send_frame(1'b0);
    gaps = 0;
    check_status("gaps", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    check_scoreboard("gaps");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
